// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter: round-robin tenures with a beat limit and ack tracking (WBARB_STATS_EN adds counters).
// Latency: grant is registered 1 cycle after cyc; data path is combinational. Backpressure: non-owner always stalled, owner sees s_stall.
module wb_arbiter2 #(
   parameter int AWIDTH    = 32,
   parameter int MAX_BEATS = 16,
   parameter int OWIDTH    = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m0_cyc,
   input  logic              m0_stb,
   input  logic              m0_we,
   input  logic [3:0]        m0_sel,
   input  logic [AWIDTH-1:0] m0_adr,
   input  logic [31:0]       m0_dat_w,
   output logic [31:0]       m0_dat_r,
   output logic              m0_ack,
   output logic              m0_stall,
   input  logic              m1_cyc,
   input  logic              m1_stb,
   input  logic              m1_we,
   input  logic [3:0]        m1_sel,
   input  logic [AWIDTH-1:0] m1_adr,
   input  logic [31:0]       m1_dat_w,
   output logic [31:0]       m1_dat_r,
   output logic              m1_ack,
   output logic              m1_stall,
   output logic              s_cyc,
   output logic              s_stb,
   output logic              s_we,
   output logic [3:0]        s_sel,
   output logic [AWIDTH-1:0] s_adr,
   output logic [31:0]       s_dat_w,
   input  logic [31:0]       s_dat_r,
   input  logic              s_ack,
   input  logic              s_stall,
   output logic [1:0]        owner
`ifdef WBARB_STATS_EN
   ,
   output logic [15:0]       grants0,
   output logic [15:0]       grants1,
   output logic [15:0]       contention
`endif
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

   localparam logic [7:0] MAXB = 8'(MAX_BEATS);

   state_t              state_q, state_d;
   logic [1:0]          owner_d;
   logic                last_q, last_d;
   logic [7:0]          beats_q, beats_d;
   logic [OWIDTH-1:0]   outst_q, outst_d;

   logic sel1, own_cyc, own_stb, oth_cyc;
   logic active, draining, at_limit, sat, pass;
   logic accept, route_ack, ack_cnt;

   // owner register doubles as the mux select; DRAIN keeps the old owner
   assign sel1     = owner[1];
   assign own_cyc  = sel1 ? m1_cyc : m0_cyc;
   assign own_stb  = sel1 ? m1_stb : m0_stb;
   assign oth_cyc  = sel1 ? m0_cyc : m1_cyc;
   assign active   = (state_q == OWN0) || (state_q == OWN1);
   assign draining = (state_q == DRAIN);
   assign at_limit = (beats_q == MAXB);
   assign sat      = &outst_q;
   assign pass     = active && !at_limit && !sat;

   assign s_cyc    = own_cyc && (active || (draining && (outst_q != '0)));
   assign s_stb    = own_cyc && own_stb && pass;
   assign s_we     = sel1 ? m1_we    : m0_we;
   assign s_sel    = sel1 ? m1_sel   : m0_sel;
   assign s_adr    = sel1 ? m1_adr   : m0_adr;
   assign s_dat_w  = sel1 ? m1_dat_w : m0_dat_w;

   assign accept    = s_stb && !s_stall;
   assign route_ack = s_ack && s_cyc;
   assign ack_cnt   = route_ack && (outst_q != '0);

   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;
   assign m0_ack   = owner[0] && route_ack;
   assign m1_ack   = owner[1] && route_ack;
   assign m0_stall = !owner[0] || !pass || s_stall;
   assign m1_stall = !owner[1] || !pass || s_stall;

   always_comb begin
      state_d = state_q;
      owner_d = owner;
      last_d  = last_q;
      beats_d = beats_q;
      outst_d = outst_q;
      if (accept && !ack_cnt)
         outst_d = outst_q + OWIDTH'(1);
      else if (!accept && ack_cnt)
         outst_d = outst_q - OWIDTH'(1);

      case (state_q)
         IDLE: begin
            outst_d = '0;
            beats_d = '0;
            if (m0_cyc && (!m1_cyc || last_q)) begin
               state_d = OWN0;
               owner_d = 2'b01;
               last_d  = 1'b0;
            end else if (m1_cyc) begin
               state_d = OWN1;
               owner_d = 2'b10;
               last_d  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            if (!own_cyc) begin
               // abort: pending acks are forfeited
               state_d = IDLE;
               owner_d = 2'b00;
               outst_d = '0;
               beats_d = '0;
            end else if (at_limit) begin
               if (oth_cyc)
                  state_d = DRAIN;
               else
                  beats_d = '0;
            end else if (accept) begin
               beats_d = beats_q + 8'd1;
            end
         end
         DRAIN: begin
            if (!own_cyc) begin
               state_d = IDLE;
               owner_d = 2'b00;
               outst_d = '0;
               beats_d = '0;
            end else if (outst_q == '0) begin
               state_d = sel1 ? OWN0 : OWN1;
               owner_d = sel1 ? 2'b01 : 2'b10;
               last_d  = !sel1;
               beats_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner   <= 2'b00;
         last_q  <= 1'b1;
         beats_q <= '0;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         owner   <= owner_d;
         last_q  <= last_d;
         beats_q <= beats_d;
         outst_q <= outst_d;
      end
   end

`ifdef WBARB_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grants0    <= '0;
         grants1    <= '0;
         contention <= '0;
      end else begin
         if (state_d == OWN0 && state_q != OWN0 && grants0 != 16'hFFFF)
            grants0 <= grants0 + 16'd1;
         if (state_d == OWN1 && state_q != OWN1 && grants1 != 16'hFFFF)
            grants1 <= grants1 + 16'd1;
         if (owner != 2'b00 && oth_cyc && contention != 16'hFFFF)
            contention <= contention + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (MAX_BEATS=4, OWIDTH=2) with a fixed-latency slave that can withhold acks.
module tb_wb_arbiter2;
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_ni;
   logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_stall;
   logic [3:0]  m0_sel;
   logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
   logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_stall;
   logic [3:0]  m1_sel;
   logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
   logic        s_cyc, s_stb, s_we, s_ack, s_stall;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic [1:0]  owner;
`ifdef WBARB_STATS_EN
   logic [15:0] grants0, grants1, contention;
`endif

   wb_arbiter2 #(.AWIDTH(32), .MAX_BEATS(4), .OWIDTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_stall(m0_stall),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_stall(m1_stall),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall),
      .owner(owner)
`ifdef WBARB_STATS_EN
      , .grants0(grants0), .grants1(grants1), .contention(contention)
`endif
   );

   int tests = 0;
   int failed = 0;

   logic        req0, req1, we0, we1, ack_en;
   int          todo0, todo1;
   logic [31:0] adr0, adr1, exp0, exp1;
   int          acks0 = 0, acks1 = 0, fwd = 0, order_err = 0;
   int          a0, a1, f;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // one clock: drive masters after the edge, account transfers at the falling edge
   task automatic step();
      @(posedge clk_i);
      #1;
      m0_cyc = req0; m0_stb = req0 && (todo0 > 0); m0_we = we0; m0_sel = 4'hF;
      m0_adr = adr0; m0_dat_w = adr0 ^ 32'hA5A5_0000;
      m1_cyc = req1; m1_stb = req1 && (todo1 > 0); m1_we = we1; m1_sel = 4'hF;
      m1_adr = adr1; m1_dat_w = adr1 ^ 32'hA5A5_0000;
      @(negedge clk_i);
      if (m0_stb && !m0_stall) begin todo0--; adr0 += 32'd4; end
      if (m1_stb && !m1_stall) begin todo1--; adr1 += 32'd4; end
      if (m0_ack) begin acks0++; if (m0_dat_r !== exp0) order_err++; exp0 += 32'd4; end
      if (m1_ack) begin acks1++; if (m1_dat_r !== exp1) order_err++; exp1 += 32'd4; end
      if (s_cyc && s_stb && !s_stall) fwd++;
   endtask

   task automatic start_m0(input logic [31:0] base, input int n, input logic we);
      req0 = 1'b1; todo0 = n; adr0 = base; exp0 = base; we0 = we;
   endtask

   task automatic start_m1(input logic [31:0] base, input int n, input logic we);
      req1 = 1'b1; todo1 = n; adr1 = base; exp1 = base; we1 = we;
   endtask

   // slave: ack two cycles after acceptance, returns the acked address as read data
   initial begin
      int          due_q[$];
      logic [31:0] adr_q[$];
      logic        acc, cyc_seen;
      logic [31:0] acc_adr;
      int          cyc_i;
      cyc_i = 0;
      s_ack = 1'b0;
      s_dat_r = '0;
      forever begin
         @(negedge clk_i);
         acc = s_cyc && s_stb && !s_stall;
         acc_adr = s_adr;
         cyc_seen = s_cyc;
         @(posedge clk_i);
         #1;
         cyc_i++;
         if (!cyc_seen) begin
            due_q.delete();
            adr_q.delete();
         end
         if (acc) begin
            due_q.push_back(cyc_i + 1);
            adr_q.push_back(acc_adr);
         end
         s_ack = 1'b0;
         if (ack_en && due_q.size() > 0 && due_q[0] <= cyc_i) begin
            s_ack = 1'b1;
            s_dat_r = adr_q[0];
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
         end
      end
   end

   initial begin
      rst_ni = 1'b0; ack_en = 1'b1; s_stall = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; todo0 = 0; todo1 = 0;
      adr0 = '0; adr1 = '0; exp0 = '0; exp1 = '0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat_w = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat_w = '0;
      repeat (3) step();
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_s_cyc", 32'(s_cyc), 32'h0);
      check("rst_s_stb", 32'(s_stb), 32'h0);
      check("rst_m0_stall", 32'(m0_stall), 32'h1);
      check("rst_m1_stall", 32'(m1_stall), 32'h1);
      check("rst_m0_ack", 32'(m0_ack), 32'h0);
      rst_ni = 1'b1;

      // m0 alone: 4 pipelined reads
      start_m0(32'h100, 4, 1'b0);
      step();
      check("t1_arb_latency_stall", 32'(m0_stall), 32'h1);
      check("t1_arb_latency_owner", 32'(owner), 32'h0);
      repeat (7) step();
      check("t1_acks0", 32'(acks0), 32'd4);
      check("t1_fwd", 32'(fwd), 32'd4);
      check("t1_acks1", 32'(acks1), 32'd0);
      check("t1_owner", 32'(owner), 32'h1);
      check("t1_m1_stall", 32'(m1_stall), 32'h1);
      check("t1_order", 32'(order_err), 32'd0);
      req0 = 1'b0;
      step();
      check("t1_drop_s_cyc", 32'(s_cyc), 32'h0);
      check("t1_drop_owner_reg", 32'(owner), 32'h1);
      step();
      check("t1_idle_owner", 32'(owner), 32'h0);

      // outstanding saturation at 3 with acks withheld
      a0 = acks0; f = fwd;
      start_m0(32'h200, 4, 1'b0);
      ack_en = 1'b0;
      repeat (5) step();
      check("t4_sat_s_stb", 32'(s_stb), 32'h0);
      check("t4_sat_m0_stall", 32'(m0_stall), 32'h1);
      repeat (2) step();
      check("t4_sat_fwd", 32'(fwd - f), 32'd3);
      ack_en = 1'b1;
      repeat (6) step();
      check("t4_release_fwd", 32'(fwd - f), 32'd4);
      check("t4_release_acks", 32'(acks0 - a0), 32'd4);
      req0 = 1'b0;
      repeat (2) step();
      check("t4_idle_owner", 32'(owner), 32'h0);

      // beat limit: m0 streams 10 writes, m1 arrives after beat 2
      a0 = acks0; a1 = acks1; f = fwd;
      start_m0(32'h300, 10, 1'b1);
      repeat (3) step();
      start_m1(32'h400, 2, 1'b1);
      step();
      check("t3_m1_waits_stall", 32'(m1_stall), 32'h1);
      check("t3_m1_waits_owner", 32'(owner), 32'h1);
      repeat (2) step();
      check("t3_limit_s_stb", 32'(s_stb), 32'h0);
      check("t3_limit_m0_stall", 32'(m0_stall), 32'h1);
      check("t3_limit_s_cyc", 32'(s_cyc), 32'h1);
      check("t3_limit_fwd", 32'(fwd - f), 32'd4);
      repeat (2) step();
      check("t3_gap_s_cyc", 32'(s_cyc), 32'h0);
      check("t3_gap_owner", 32'(owner), 32'h1);
      check("t3_drain_acks0", 32'(acks0 - a0), 32'd4);
      step();
      check("t3_m1_owner", 32'(owner), 32'h2);
      check("t3_m1_s_adr", s_adr, 32'h400);
      check("t3_m1_s_dat_w", s_dat_w, 32'h400 ^ 32'hA5A5_0000);
      check("t3_m1_s_we", 32'(s_we), 32'h1);
      check("t3_m0_stalled", 32'(m0_stall), 32'h1);
      repeat (3) step();
      check("t3_m1_acks", 32'(acks1 - a1), 32'd2);
      req1 = 1'b0;
      repeat (3) step();
      check("t3_m0_back_owner", 32'(owner), 32'h1);
      check("t3_m0_back_s_stb", 32'(s_stb), 32'h1);
      check("t3_m0_back_s_adr", s_adr, 32'h310);
      repeat (12) step();
      check("t3_m0_acks", 32'(acks0 - a0), 32'd10);
      check("t3_fwd", 32'(fwd - f), 32'd12);
      check("t3_order", 32'(order_err), 32'd0);
      req0 = 1'b0;
      repeat (2) step();

      // reset mid-burst with 2 outstanding
      start_m0(32'h500, 2, 1'b0);
      ack_en = 1'b0;
      repeat (4) step();
      check("t5_pre_s_cyc", 32'(s_cyc), 32'h1);
      check("t5_pre_owner", 32'(owner), 32'h1);
      rst_ni = 1'b0;
      #1;
      check("t5_rst_s_cyc", 32'(s_cyc), 32'h0);
      check("t5_rst_s_stb", 32'(s_stb), 32'h0);
      check("t5_rst_owner", 32'(owner), 32'h0);
      check("t5_rst_m0_stall", 32'(m0_stall), 32'h1);
      req0 = 1'b0; todo0 = 0;
      repeat (2) step();
      ack_en = 1'b1;
      rst_ni = 1'b1;

      // simultaneous request after reset: m0 first, then m1; counters restart from 0
      a0 = acks0; a1 = acks1; f = fwd;
      start_m0(32'h600, 3, 1'b0);
      start_m1(32'h700, 1, 1'b0);
      ack_en = 1'b0;
      step();
      check("t2_c1_owner", 32'(owner), 32'h0);
      step();
      check("t2_m0_first", 32'(owner), 32'h1);
      check("t2_m1_stall", 32'(m1_stall), 32'h1);
      repeat (3) step();
      check("t2_cleared_fwd", 32'(fwd - f), 32'd3);
      check("t2_cleared_sat", 32'(s_stb), 32'h0);
      ack_en = 1'b1;
      repeat (4) step();
      check("t2_m0_acks", 32'(acks0 - a0), 32'd3);
      req0 = 1'b0;
      repeat (3) step();
      check("t2_m1_owner", 32'(owner), 32'h2);
      repeat (3) step();
      check("t2_m1_acks", 32'(acks1 - a1), 32'd1);
      req1 = 1'b0;
      repeat (2) step();
      check("t2_final_owner", 32'(owner), 32'h0);
      check("t2_final_s_cyc", 32'(s_cyc), 32'h0);
      check("t2_order", 32'(order_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
